// File: rtl/pio_tlp_completer.sv
// Programmed-I/O completer for a 64-bit AXI-Stream PCIe endpoint.
// Accepts MemRd32/MemWr32 of length 1 DW against a small register bank,
// returns a two-beat CplD for reads, and counts every dropped request.
module pio_tlp_completer #(
    parameter logic [15:0] COMPLETER_ID = 16'h0100,
    parameter int          NUM_REGS     = 16
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tvalid,
    input  logic        m_axis_rx_tlast,
    output logic        m_axis_rx_tready,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tvalid,
    output logic        s_axis_tx_tlast,
    input  logic        s_axis_tx_tready,
    output logic [15:0] unsupported_cnt,
    output logic        busy
);

    localparam int         IDX_W    = $clog2(NUM_REGS);
    localparam logic [6:0] FT_MRD32 = 7'b00_00000;
    localparam logic [6:0] FT_MWR32 = 7'b10_00000;
    localparam logic [6:0] FT_CPLD  = 7'b10_01010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR2  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CPL0  = 3'd3,
        ST_CPL1  = 3'd4
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Request header fields captured from the first beat
    logic [6:0]  fmt_type_reg;
    logic [9:0]  length_reg;
    logic [2:0]  tc_reg;
    logic [1:0]  attr_reg;
    logic [15:0] req_id_reg;
    logic [7:0]  tag_reg;
    logic [3:0]  first_be_reg;

    // Completion payload captured when the read is accepted
    logic [31:0] cpl_data_reg;
    logic [6:0]  lower_addr_reg;

    // Registered stream outputs
    logic        rx_tready_reg;
    logic        tx_tvalid_reg;
    logic        tx_tlast_reg;
    logic [63:0] tx_tdata_reg;
    logic [63:0] tx_tdata_next;
    logic [15:0] unsup_cnt_reg;

    logic [31:0] reg_bank [NUM_REGS];

    logic             rx_accept;
    logic             tx_accept;
    logic             hdr_is_mrd;
    logic             hdr_is_mwr;
    logic             count_unsup;
    logic             wr_en;
    logic             rd_capture;
    logic [IDX_W-1:0] reg_idx;
    logic [31:0]      beat_dw2;
    logic [31:0]      beat_dw3;
    logic [31:0]      cpl_dw0;
    logic [31:0]      cpl_dw1;
    logic [31:0]      cpl_dw2;
    logic             unused_inputs;

    // Byte enables and the header bits we do not decode are intentionally ignored
    assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tdata};

    assign rx_accept  = m_axis_rx_tvalid && rx_tready_reg;
    assign tx_accept  = tx_tvalid_reg && s_axis_tx_tready;
    assign hdr_is_mrd = (fmt_type_reg == FT_MRD32) && (length_reg == 10'd1);
    assign hdr_is_mwr = (fmt_type_reg == FT_MWR32) && (length_reg == 10'd1);

    // Second beat carries {DW3, DW2}; upper address bits alias onto the bank
    assign beat_dw2 = m_axis_rx_tdata[31:0];
    assign beat_dw3 = m_axis_rx_tdata[63:32];
    assign reg_idx  = beat_dw2[IDX_W+1:2];

    // Completion header words
    assign cpl_dw0 = {1'b0, FT_CPLD, 1'b0, tc_reg, 4'b0000, 1'b0, 1'b0,
                      attr_reg, 2'b00, 10'd1};
    assign cpl_dw1 = {COMPLETER_ID, 3'b000, 1'b0, 12'd4};
    assign cpl_dw2 = {req_id_reg, tag_reg, 1'b0, lower_addr_reg};

    // State register
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and per-beat action strobes
    always_comb begin
        state_next  = state_reg;
        count_unsup = 1'b0;
        wr_en       = 1'b0;
        rd_capture  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_accept) begin
                    if (m_axis_rx_tlast) begin
                        // A one-beat TLP can never be a valid 3DW request
                        count_unsup = 1'b1;
                    end else begin
                        state_next = ST_HDR2;
                    end
                end
            end
            ST_HDR2: begin
                if (rx_accept) begin
                    if (hdr_is_mrd && m_axis_rx_tlast) begin
                        rd_capture = 1'b1;
                        state_next = ST_CPL0;
                    end else begin
                        // Writes still land even if trailing beats follow;
                        // a read with trailing beats is malformed and dropped
                        if (hdr_is_mwr) begin
                            wr_en = 1'b1;
                        end else begin
                            count_unsup = 1'b1;
                        end
                        state_next = m_axis_rx_tlast ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_accept && m_axis_rx_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CPL0: begin
                if (tx_accept) begin
                    state_next = ST_CPL1;
                end
            end
            ST_CPL1: begin
                if (tx_accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Completion beat contents for the state being entered
    always_comb begin
        tx_tdata_next = '0;
        case (state_next)
            ST_CPL0: tx_tdata_next = {cpl_dw1, cpl_dw0};
            ST_CPL1: tx_tdata_next = {cpl_data_reg, cpl_dw2};
            default: tx_tdata_next = '0;
        endcase
    end

    // Stream handshake outputs are registered off the next state so tx_tvalid
    // never depends combinationally on tx_tready and beats hold while stalled
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rx_tready_reg <= 1'b0;
            tx_tvalid_reg <= 1'b0;
            tx_tlast_reg  <= 1'b0;
            tx_tdata_reg  <= '0;
        end else begin
            rx_tready_reg <= (state_next == ST_IDLE) || (state_next == ST_HDR2) ||
                             (state_next == ST_DRAIN);
            tx_tvalid_reg <= (state_next == ST_CPL0) || (state_next == ST_CPL1);
            tx_tlast_reg  <= (state_next == ST_CPL1);
            tx_tdata_reg  <= tx_tdata_next;
        end
    end

    // Latch the first-beat header fields
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            fmt_type_reg <= '0;
            length_reg   <= '0;
            tc_reg       <= '0;
            attr_reg     <= '0;
            req_id_reg   <= '0;
            tag_reg      <= '0;
            first_be_reg <= '0;
        end else if ((state_reg == ST_IDLE) && rx_accept) begin
            fmt_type_reg <= m_axis_rx_tdata[30:24];
            length_reg   <= m_axis_rx_tdata[9:0];
            tc_reg       <= m_axis_rx_tdata[22:20];
            attr_reg     <= m_axis_rx_tdata[13:12];
            req_id_reg   <= m_axis_rx_tdata[63:48];
            tag_reg      <= m_axis_rx_tdata[47:40];
            first_be_reg <= m_axis_rx_tdata[35:32];
        end
    end

    // Registered read of the addressed word for the completion
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            cpl_data_reg   <= '0;
            lower_addr_reg <= '0;
        end else if (rd_capture) begin
            cpl_data_reg   <= reg_bank[reg_idx];
            lower_addr_reg <= beat_dw2[6:0];
        end
    end

    // Saturating count of dropped requests
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            unsup_cnt_reg <= '0;
        end else if (count_unsup && (unsup_cnt_reg != 16'hFFFF)) begin
            unsup_cnt_reg <= unsup_cnt_reg + 16'd1;
        end
    end

    // Register bank: one resettable word per entry with byte-enabled writes
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [IDX_W-1:0] REG_IDX = IDX_W'(gi);
            logic [31:0] word_reg;

            // Byte-enabled write of this bank word
            always_ff @(posedge user_clk) begin
                if (user_reset) begin
                    word_reg <= '0;
                end else if (wr_en && (reg_idx == REG_IDX)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (first_be_reg[b]) begin
                            word_reg[8*b +: 8] <= beat_dw3[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_bank[gi] = word_reg;
        end
    endgenerate

    assign m_axis_rx_tready = rx_tready_reg;
    assign s_axis_tx_tdata  = tx_tdata_reg;
    assign s_axis_tx_tkeep  = tx_tvalid_reg ? 8'hFF : 8'h00;
    assign s_axis_tx_tvalid = tx_tvalid_reg;
    assign s_axis_tx_tlast  = tx_tlast_reg;
    assign unsupported_cnt  = unsup_cnt_reg;
    assign busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pio_tlp_completer.sv
// Bench for pio_tlp_completer: directed scenarios plus randomized TLP traffic,
// with a register-bank reference model feeding a completion scoreboard.
module tb_pio_tlp_completer;

    localparam int NUM_REGS = 16;

    typedef struct {
        logic [63:0] b0;
        logic [63:0] b1;
    } cpl_t;

    logic        user_clk;
    logic        user_reset;
    logic [63:0] rx_tdata;
    logic [7:0]  rx_tkeep;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic        rx_tready;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic        tx_tready;
    logic [15:0] unsupported_cnt;
    logic        busy;

    int          pass_cnt;
    int          total_cnt;
    cpl_t        exp_q[$];
    logic [31:0] model_regs [NUM_REGS];
    logic [15:0] model_unsup;
    logic [63:0] tlp_beats [4];
    int          tr_mode;
    bit          mon_en;
    bit          beat_idx;

    pio_tlp_completer #(
        .COMPLETER_ID(16'h0100),
        .NUM_REGS    (NUM_REGS)
    ) dut (
        .user_clk        (user_clk),
        .user_reset      (user_reset),
        .m_axis_rx_tdata (rx_tdata),
        .m_axis_rx_tkeep (rx_tkeep),
        .m_axis_rx_tvalid(rx_tvalid),
        .m_axis_rx_tlast (rx_tlast),
        .m_axis_rx_tready(rx_tready),
        .s_axis_tx_tdata (tx_tdata),
        .s_axis_tx_tkeep (tx_tkeep),
        .s_axis_tx_tvalid(tx_tvalid),
        .s_axis_tx_tlast (tx_tlast),
        .s_axis_tx_tready(tx_tready),
        .unsupported_cnt (unsupported_cnt),
        .busy            (busy)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Assemble a 3DW request: beat0={DW1,DW0}, beat1={DW3,DW2}, filler after
    task automatic build(input logic [6:0] ft, input logic [9:0] len, input logic [2:0] tc,
                         input logic [1:0] attr, input logic [15:0] rid, input logic [7:0] tag,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {1'b0, ft, 1'b0, tc, 4'b0000, 2'b00, attr, 2'b00, len};
        dw1 = {rid, tag, 4'b0000, be};
        tlp_beats[0] = {dw1, dw0};
        tlp_beats[1] = {data, addr};
        tlp_beats[2] = {$urandom, $urandom};
        tlp_beats[3] = {$urandom, $urandom};
    endtask

    task automatic bump_unsup();
        if (model_unsup != 16'hFFFF) model_unsup = model_unsup + 16'd1;
    endtask

    // Reference behaviour of one TLP of nb beats (tlast on the final beat)
    task automatic model_tlp(input int nb, input bit push_it);
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
        logic [31:0] dw3;
        int          idx;
        cpl_t        c;
        dw0 = tlp_beats[0][31:0];
        dw1 = tlp_beats[0][63:32];
        dw2 = tlp_beats[1][31:0];
        dw3 = tlp_beats[1][63:32];
        if (nb < 2) begin
            bump_unsup();
            return;
        end
        idx = int'((dw2 >> 2) % NUM_REGS);
        if (dw0[30:24] == 7'h40 && dw0[9:0] == 10'd1) begin
            for (int b = 0; b < 4; b++) begin
                if (dw1[b]) model_regs[idx][8*b +: 8] = dw3[8*b +: 8];
            end
        end else if (dw0[30:24] == 7'h00 && dw0[9:0] == 10'd1 && nb == 2) begin
            if (push_it) begin
                c.b0 = {32'h01000004,
                        32'h4A000001 | (32'(dw0[22:20]) << 20) | (32'(dw0[13:12]) << 12)};
                c.b1 = {model_regs[idx], dw1[31:16], dw1[15:8], 1'b0, dw2[6:0]};
                exp_q.push_back(c);
            end
        end else begin
            bump_unsup();
        end
    endtask

    task automatic push_const(input logic [63:0] b0, input logic [63:0] b1);
        cpl_t c;
        c.b0 = b0;
        c.b1 = b1;
        exp_q.push_back(c);
    endtask

    // Drive nb beats back to back; each beat waits (bounded) for rx_tready
    task automatic send_tlp(input int nb);
        int n;
        bit acc;
        @(posedge user_clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            rx_tdata  = tlp_beats[i];
            rx_tlast  = (i == nb - 1);
            rx_tvalid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 3000) begin
                @(negedge user_clk);
                acc = rx_tready;
                @(posedge user_clk);
                #1;
                n++;
            end
            if (!acc) begin
                total_cnt++;
                $display("FAIL rx_accept_timeout: beat %0d not accepted after %0d cycles", i, n);
                break;
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && n < 3000) begin
            @(negedge user_clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        check("drain_tx_idle", 64'(tx_tvalid), 64'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        model_unsup = '0;
        exp_q.delete();
    endtask

    // Link-side ready: random, held low, or held high
    initial begin
        tx_tready = 1'b0;
        forever begin
            @(posedge user_clk);
            #1;
            case (tr_mode)
                0:       tx_tready = ($urandom_range(0, 2) != 0);
                1:       tx_tready = 1'b0;
                default: tx_tready = 1'b1;
            endcase
        end
    end

    // Completion monitor: pops the scoreboard on every accepted beat
    initial begin
        cpl_t        e;
        bit          was_stalled;
        logic [63:0] held;
        was_stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge user_clk);
            if (mon_en && tx_tvalid) begin
                check("rx_tready_low_in_cpl", 64'(rx_tready), 64'd0);
                check("tx_tkeep", 64'(tx_tkeep), 64'hFF);
                check("tx_tlast_position", 64'(tx_tlast), 64'(beat_idx));
                if (was_stalled) check("tx_beat_stable", tx_tdata, held);
                if (tx_tready) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_cpl: got beat %h required no completion", tx_tdata);
                    end else begin
                        e = exp_q[0];
                        if (beat_idx == 1'b0) begin
                            check("cpl_beat0", tx_tdata, e.b0);
                        end else begin
                            check("cpl_beat1", tx_tdata, e.b1);
                            void'(exp_q.pop_front());
                            $display("cpl done: beat0=%h beat1=%h", e.b0, e.b1);
                        end
                    end
                    beat_idx = ~beat_idx;
                    was_stalled = 1'b0;
                end else begin
                    was_stalled = 1'b1;
                    held = tx_tdata;
                end
            end else begin
                was_stalled = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [6:0]  ft;
        logic [9:0]  len;
        int          nb;
        int          sel;

        pass_cnt   = 0;
        total_cnt  = 0;
        tr_mode    = 0;
        mon_en     = 1'b1;
        beat_idx   = 1'b0;
        user_reset = 1'b1;
        rx_tdata   = '0;
        rx_tkeep   = 8'hFF;
        rx_tvalid  = 1'b0;
        rx_tlast   = 1'b0;
        clear_model();

        // Reset values
        repeat (3) @(negedge user_clk);
        check("rst_rx_tready", 64'(rx_tready), 64'd0);
        check("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_tx_tlast", 64'(tx_tlast), 64'd0);
        check("rst_tx_tdata", tx_tdata, 64'd0);
        check("rst_unsup_cnt", 64'(unsupported_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        user_reset = 1'b0;
        @(negedge user_clk);
        check("rx_tready_after_reset", 64'(rx_tready), 64'd1);

        // Length-2 MemRd and a Cfg request are both dropped, then a good read
        build(7'h00, 10'd2, 3'd0, 2'd0, 16'h1234, 8'h01, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'b0000100, 10'd1, 3'd0, 2'd0, 16'h1234, 8'h02, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 1);
        send_tlp(2);
        repeat (3) @(negedge user_clk);
        check("unsup_cnt_two_drops", 64'(unsupported_cnt), 64'd2);
        build(7'h00, 10'd1, 3'd5, 2'd2, 16'hBEEF, 8'h33, 4'hF, 32'h0C, 32'h0);
        model_tlp(2, 1);
        send_tlp(2);
        wait_drain();

        // Write 0xDEADBEEF at 0x08 then read it back with tag 5
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 4'hF, 32'h08, 32'hDEADBEEF);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h05, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 0);
        push_const({32'h01000004, 32'h4A000001}, {32'hDEADBEEF, 32'h00000508});
        send_tlp(2);
        check("read_latency_tvalid", 64'(tx_tvalid), 64'd1);
        wait_drain();

        // Partial byte-enable write over a known pattern
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 4'hF, 32'h10, 32'hAAAAAAAA);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 4'b0011, 32'h10, 32'h11223344);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h21, 4'hF, 32'h10, 32'h0);
        model_tlp(2, 0);
        push_const({32'h01000004, 32'h4A000001}, {32'hAAAA3344, 32'h00002110});
        send_tlp(2);
        wait_drain();

        // Address aliasing: 0x48 lands on the same word as 0x08
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h00, 4'hF, 32'h48, 32'h12345678);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h07, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 0);
        push_const({32'h01000004, 32'h4A000001}, {32'h12345678, 32'h00000708});
        send_tlp(2);
        wait_drain();

        // Back-pressure during CPL0 for five cycles
        tr_mode = 1;
        build(7'h00, 10'd1, 3'd1, 2'd1, 16'hCAFE, 8'h09, 4'hF, 32'h48, 32'h0);
        model_tlp(2, 1);
        send_tlp(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge user_clk);
            check("stall_cpl0_tvalid", 64'(tx_tvalid), 64'd1);
            check("stall_cpl0_tlast", 64'(tx_tlast), 64'd0);
        end
        tr_mode = 2;
        @(negedge user_clk);
        @(negedge user_clk);
        check("beat1_follows_valid", 64'(tx_tvalid), 64'd1);
        check("beat1_follows_tlast", 64'(tx_tlast), 64'd1);
        tr_mode = 0;
        wait_drain();

        // Malformed read (extra beat), one-beat TLP, and an empty-byte-enable write
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0001, 8'h11, 4'hF, 32'h04, 32'h0);
        model_tlp(3, 1);
        send_tlp(3);
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0001, 8'h12, 4'hF, 32'h04, 32'h0);
        model_tlp(1, 1);
        send_tlp(1);
        build(7'h40, 10'd1, 3'd0, 2'd0, 16'h0001, 8'h13, 4'h0, 32'h08, 32'hFFFFFFFF);
        model_tlp(2, 1);
        send_tlp(2);
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0001, 8'h14, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 1);
        send_tlp(2);
        wait_drain();
        repeat (2) @(negedge user_clk);
        check("unsup_cnt_malformed", 64'(unsupported_cnt), 64'(model_unsup));

        // Reset while CPL1 is stalled abandons the completion
        mon_en = 1'b0;
        tr_mode = 1;
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h0A, 4'hF, 32'h08, 32'h0);
        send_tlp(2);
        @(negedge user_clk);
        tr_mode = 2;
        @(negedge user_clk);
        tr_mode = 1;
        @(negedge user_clk);
        check("cpl1_reached", 64'(tx_tlast), 64'd1);
        user_reset = 1'b1;
        @(negedge user_clk);
        check("rst_cpl1_tvalid", 64'(tx_tvalid), 64'd0);
        check("rst_cpl1_tdata", tx_tdata, 64'd0);
        check("rst_cpl1_busy", 64'(busy), 64'd0);
        check("rst_cpl1_unsup", 64'(unsupported_cnt), 64'd0);
        check("rst_cpl1_rx_tready", 64'(rx_tready), 64'd0);
        user_reset = 1'b0;
        clear_model();
        beat_idx = 1'b0;
        tr_mode = 0;
        mon_en = 1'b1;
        @(negedge user_clk);
        check("rx_tready_after_midreset", 64'(rx_tready), 64'd1);
        build(7'h00, 10'd1, 3'd0, 2'd0, 16'h0000, 8'h0B, 4'hF, 32'h08, 32'h0);
        model_tlp(2, 0);
        push_const({32'h01000004, 32'h4A000001}, {32'h00000000, 32'h00000B08});
        send_tlp(2);
        wait_drain();

        // Randomized traffic against the reference model
        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1, 2: ft = 7'h40;
                3, 4, 5: ft = 7'h00;
                6:       ft = 7'b0000100;
                default: ft = 7'($urandom);
            endcase
            len = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'd1;
            sel = $urandom_range(0, 9);
            nb = (sel == 0) ? 1 : ((sel == 1) ? int'($urandom_range(3, 4)) : 2);
            build(ft, len, 3'($urandom), 2'($urandom), 16'($urandom), 8'($urandom),
                  4'($urandom), $urandom, $urandom);
            model_tlp(nb, 1);
            send_tlp(nb);
        end
        wait_drain();
        repeat (2) @(negedge user_clk);
        check("unsup_cnt_random", 64'(unsupported_cnt), 64'(model_unsup));
        check("busy_idle_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
